adc_capture_arbiter: RTL and testbench
======================================

Name: adc_capture_arbiter

Overview:
- Shares the single PS-bound AXIS output among up to 16 ADC capture streams.
- Grants one enabled, requesting channel at a time, round-robin, for a fixed-length burst.
- Each wide ADC beat is serialized into narrow PS words; the last word of a burst is marked with tlast.
- Sits between the ADC slave ports and the PS return stream inside the PL controller, all at 250 MHz.

Parameters:
- NUM_CH, 16, number of ADC input channels.
- IN_WIDTH, 128, ADC beat width in bits; must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 32, PS stream width in bits; equals ps_axis_width.
- BURST_BEATS, 64, ADC beats captured per grant; must be ≥1.

Ports:
- clk  in  1  system clock, 250 MHz.
- rst  in  1  reset; synchronous, active-low.
- ch_en  in  NUM_CH  per-channel enable, driven from gpio_ctrl.
- s_axis_tdata  in  NUM_CH*IN_WIDTH  flattened ADC data; channel k occupies bits [k*IN_WIDTH +: IN_WIDTH].
- s_axis_tvalid  in  NUM_CH  per-channel valid.
- s_axis_tready  out  NUM_CH  per-channel ready.
- m_axis_tdata  out  OUT_WIDTH  serialized word to PS.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  PS ready.
- m_axis_tlast  out  1  last word of the burst.
- busy  out  1  high in any state other than IDLE.
- cur_ch  out  $clog2(NUM_CH)  channel currently granted.

Behaviour:
- WPB = IN_WIDTH/OUT_WIDTH words per beat (4 by default).
- Reset (rst=0 at a clk edge):
  - state=IDLE; s_axis_tready=0; m_axis_tvalid=0; m_axis_tlast=0; m_axis_tdata=0; busy=0; cur_ch=0.
  - beat_cnt=0; word_cnt=0; last_grant=NUM_CH-1, so channel 0 wins first.
  - Reset mid-burst discards the shift register and any partial burst. No tlast is issued.
- States: IDLE, ACCEPT, SHIFT (plus HDR when the optional feature is compiled in).
- IDLE:
  - req = ch_en & s_axis_tvalid.
  - If req≠0, grant the first set bit searching from last_grant+1 upward with wrap-around.
  - Register the grant into cur_ch, clear beat_cnt, then go to ACCEPT.
  - If req=0, stay in IDLE.
- ACCEPT:
  - s_axis_tready[cur_ch]=1; all other tready bits are 0. tready is decoded from registered state only.
  - On s_axis_tvalid[cur_ch]=1: load the IN_WIDTH shift register, set word_cnt=0, go to SHIFT.
  - If tvalid is low, wait indefinitely. No timeout and no regrant.
- SHIFT:
  - m_axis_tvalid=1; m_axis_tdata = shift register [OUT_WIDTH-1:0]. Words go out LSB first.
  - Data is held stable while m_axis_tready=0.
  - On handshake: shift right by OUT_WIDTH and increment word_cnt.
  - When word_cnt=WPB-1 is accepted, increment beat_cnt. Then:
    - if beat_cnt=BURST_BEATS-1: last_grant=cur_ch, go to IDLE;
    - else go to ACCEPT.
  - m_axis_tlast=1 only on word WPB-1 of beat BURST_BEATS-1.
- Latency and throughput:
  - A request seen in IDLE at cycle N gives tready at N+1.
  - A handshake at N+1 gives the first m_axis_tvalid at N+2.
  - Steady state is WPB+1 cycles per beat with PS tready held high.
- ch_en is sampled only in IDLE. Deasserting it mid-burst does not abort the burst.
- Simultaneous requests are resolved strictly by round-robin order; no channel is granted twice while another enabled requester is waiting.
- Ungranted channels see tready=0. Their data is back-pressured, not dropped.

Optional Feature:
- Macro: ADC_ARB_HDR_EN.
- When defined:
  - IDLE goes to HDR instead of ACCEPT.
  - HDR emits one word {8'hA5, 8'(cur_ch), 16'(burst_seq)} with m_axis_tlast=0, then goes to ACCEPT on handshake.
  - burst_seq is a 16-bit counter that increments when each burst completes, wraps 0xFFFF→0x0000, and resets to 0.
  - Requires OUT_WIDTH ≥ 32; the upper bits are zero-padded.
- When undefined: no HDR state, no burst_seq logic, and bursts start directly with data.

Test Plan:
- Single channel: ch_en=0x0001, ch0 beats 0x00000003_00000002_00000001_00000000 and onward, PS tready=1, BURST_BEATS=2 → words 0,1,2,3,… in order; tlast on the 8th word; busy low after it; other tready bits stay 0.
- Round-robin: ch_en=0x8005, channels 0, 2 and 15 continuously valid → grant order 0, 2, 15, 0, 2; cur_ch matches each burst.
- Back-pressure: m_axis_tready toggled 1,0,0,1 during SHIFT → tdata stable while stalled; no word lost or duplicated; 4 words per beat preserved.
- Disable mid-burst: ch_en 0x0002→0x0000 at beat 3 of 64 → burst still completes all 64 beats with tlast; then stays in IDLE.
- Reset mid-burst: rst=0 for 1 cycle during SHIFT → next cycle all outputs 0 and state IDLE; next grant goes to channel 0 if it is requesting.
- ADC_ARB_HDR_EN build: two bursts on channel 5 → header words 0xA5050000 then 0xA5050001, each before its burst's data.

Source files
------------

// File: rtl/adc_capture_arbiter.sv
// adc_capture_arbiter: round-robin arbiter that grants one enabled ADC stream at a time for a
// fixed-length burst and serializes each wide beat into narrow PS words, LSB word first.
// Optional burst header word: define ADC_ARB_HDR_EN.
// NUM_CH is expected to be a power of two >= 2 so cur_ch indexes every channel exactly.
module adc_capture_arbiter #(
   parameter int unsigned NUM_CH      = 16,
   parameter int unsigned IN_WIDTH    = 128,
   parameter int unsigned OUT_WIDTH   = 32,
   parameter int unsigned BURST_BEATS = 64
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_CH-1:0]           ch_en,
   input  logic [NUM_CH*IN_WIDTH-1:0]  s_axis_tdata,
   input  logic [NUM_CH-1:0]           s_axis_tvalid,
   output logic [NUM_CH-1:0]           s_axis_tready,
   output logic [OUT_WIDTH-1:0]        m_axis_tdata,
   output logic                        m_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic                        m_axis_tlast,
   output logic                        busy,
   output logic [$clog2(NUM_CH)-1:0]   cur_ch
);

   localparam int unsigned ChW = $clog2(NUM_CH);
   localparam int unsigned Wpb = IN_WIDTH / OUT_WIDTH;
   localparam int unsigned WcW = (Wpb > 1) ? $clog2(Wpb) : 1;
   localparam int unsigned BcW = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;

`ifdef ADC_ARB_HDR_EN
   typedef enum logic [1:0] {StIdle, StAccept, StShift, StHdr} state_e;
`else
   typedef enum logic [1:0] {StIdle, StAccept, StShift} state_e;
`endif

   state_e               state_q, state_d;
   logic [ChW-1:0]       cur_ch_q, cur_ch_d;
   logic [ChW-1:0]       last_grant_q, last_grant_d;
   logic [BcW-1:0]       beat_cnt_q, beat_cnt_d;
   logic [WcW-1:0]       word_cnt_q, word_cnt_d;
   logic [IN_WIDTH-1:0]  shreg_q, shreg_d;
`ifdef ADC_ARB_HDR_EN
   logic [15:0]          burst_seq_q, burst_seq_d;
`endif

   logic [NUM_CH-1:0]    req;
   logic                 grant_found;
   logic [ChW-1:0]       grant_ch;
   logic [ChW-1:0]       idx;
   logic                 last_word;
   logic                 last_beat;

   assign req    = ch_en & s_axis_tvalid;
   assign busy   = (state_q != StIdle);
   assign cur_ch = cur_ch_q;

   // Round-robin search: first requester after last_grant, wrapping around.
   always_comb begin
      grant_found = 1'b0;
      grant_ch    = '0;
      idx         = '0;
      for (int unsigned i = 1; i <= NUM_CH; i++) begin
         idx = ChW'((32'(last_grant_q) + i) % NUM_CH);
         if (!grant_found && req[idx]) begin
            grant_found = 1'b1;
            grant_ch    = idx;
         end
      end
   end

   // Next-state and output decode; all outputs derive from registered state.
   always_comb begin
      state_d       = state_q;
      cur_ch_d      = cur_ch_q;
      last_grant_d  = last_grant_q;
      beat_cnt_d    = beat_cnt_q;
      word_cnt_d    = word_cnt_q;
      shreg_d       = shreg_q;
`ifdef ADC_ARB_HDR_EN
      burst_seq_d   = burst_seq_q;
`endif
      s_axis_tready = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = '0;
      m_axis_tlast  = 1'b0;
      last_word     = (word_cnt_q == WcW'(Wpb - 1));
      last_beat     = (beat_cnt_q == BcW'(BURST_BEATS - 1));
      unique case (state_q)
         StIdle: begin
            if (grant_found) begin
               cur_ch_d   = grant_ch;
               beat_cnt_d = '0;
`ifdef ADC_ARB_HDR_EN
               state_d    = StHdr;
`else
               state_d    = StAccept;
`endif
            end
         end
         StAccept: begin
            s_axis_tready[cur_ch_q] = 1'b1;
            if (s_axis_tvalid[cur_ch_q]) begin
               shreg_d    = s_axis_tdata[32'(cur_ch_q)*IN_WIDTH +: IN_WIDTH];
               word_cnt_d = '0;
               state_d    = StShift;
            end
         end
         StShift: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = shreg_q[OUT_WIDTH-1:0];
            m_axis_tlast  = last_word && last_beat;
            if (m_axis_tready) begin
               shreg_d    = shreg_q >> OUT_WIDTH;
               word_cnt_d = word_cnt_q + 1'b1;
               if (last_word) begin
                  beat_cnt_d = beat_cnt_q + 1'b1;
                  if (last_beat) begin
                     last_grant_d = cur_ch_q;
                     state_d      = StIdle;
`ifdef ADC_ARB_HDR_EN
                     burst_seq_d  = burst_seq_q + 16'd1;
`endif
                  end else begin
                     state_d = StAccept;
                  end
               end
            end
         end
`ifdef ADC_ARB_HDR_EN
         StHdr: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = OUT_WIDTH'({8'hA5, 8'(cur_ch_q), burst_seq_q});
            if (m_axis_tready) begin
               state_d = StAccept;
            end
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   // State registers with synchronous active-low reset; reset drops any partial burst.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= StIdle;
         cur_ch_q     <= '0;
         last_grant_q <= ChW'(NUM_CH - 1);
         beat_cnt_q   <= '0;
         word_cnt_q   <= '0;
         shreg_q      <= '0;
`ifdef ADC_ARB_HDR_EN
         burst_seq_q  <= '0;
`endif
      end else begin
         state_q      <= state_d;
         cur_ch_q     <= cur_ch_d;
         last_grant_q <= last_grant_d;
         beat_cnt_q   <= beat_cnt_d;
         word_cnt_q   <= word_cnt_d;
         shreg_q      <= shreg_d;
`ifdef ADC_ARB_HDR_EN
         burst_seq_q  <= burst_seq_d;
`endif
      end
   end

endmodule

// File: tb/tb_adc_capture_arbiter.sv
// tb_adc_capture_arbiter: directed stimulus with a scoreboard queue of expected PS words;
// a negedge monitor pops and compares every accepted output word.
module tb_adc_capture_arbiter;

   localparam int unsigned NCH = 16;
   localparam int unsigned IW  = 128;
   localparam int unsigned OW  = 32;
   localparam int unsigned BB  = 2;
   localparam int unsigned WPB = IW / OW;
`ifdef ADC_ARB_HDR_EN
   localparam int unsigned HW  = 1;
`else
   localparam int unsigned HW  = 0;
`endif
   localparam int unsigned BW  = BB * WPB + HW;

   logic              clk = 1'b0;
   logic              rst;
   logic [NCH-1:0]    ch_en;
   logic [NCH*IW-1:0] s_axis_tdata;
   logic [NCH-1:0]    s_axis_tvalid;
   logic [NCH-1:0]    s_axis_tready;
   logic [OW-1:0]     m_axis_tdata;
   logic              m_axis_tvalid;
   logic              m_axis_tready;
   logic              m_axis_tlast;
   logic              busy;
   logic [3:0]        cur_ch;

   adc_capture_arbiter #(
      .NUM_CH(NCH), .IN_WIDTH(IW), .OUT_WIDTH(OW), .BURST_BEATS(BB)
   ) dut (
      .clk(clk), .rst(rst), .ch_en(ch_en),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_axis_tlast), .busy(busy), .cur_ch(cur_ch)
   );

   always #5 clk = ~clk;

   int unsigned errors = 0;
   int unsigned checks = 0;
   int unsigned hs_cnt = 0;

   // Source model: channel k, beat n, word j carries {k, n*WPB+j}.
   function automatic logic [OW-1:0] word_of(input int unsigned ch, input int unsigned beat,
                                             input int unsigned j);
      return OW'((ch << 24) | (beat * WPB + j));
   endfunction

   int unsigned    src_n [NCH] = '{default: 0};
   logic [NCH-1:0] src_v;
   assign s_axis_tvalid = src_v;

   always_comb begin
      s_axis_tdata = '0;
      for (int unsigned k = 0; k < NCH; k++)
         for (int unsigned j = 0; j < WPB; j++)
            s_axis_tdata[k*IW + j*OW +: OW] = word_of(k, src_n[k], j);
   end

   always @(posedge clk) begin
      for (int unsigned k = 0; k < NCH; k++)
         if (rst && src_v[k] && s_axis_tready[k]) src_n[k] <= src_n[k] + 1;
   end

   // Expected-value model and scoreboard
   typedef struct {
      logic [OW-1:0] data;
      logic          last;
      logic [3:0]    ch;
   } exp_t;
   exp_t        sb [$];
   int unsigned exp_n [NCH] = '{default: 0};
   logic [15:0] exp_seq = '0;

   task automatic push_hdr(input int unsigned ch);
`ifdef ADC_ARB_HDR_EN
      sb.push_back('{data: {8'hA5, 8'(ch), exp_seq}, last: 1'b0, ch: 4'(ch)});
`else
      if (ch >= NCH) $display("bad channel %0d", ch);
`endif
   endtask

   task automatic push_burst(input int unsigned ch);
      push_hdr(ch);
      for (int unsigned b = 0; b < BB; b++) begin
         for (int unsigned j = 0; j < WPB; j++)
            sb.push_back('{data: word_of(ch, exp_n[ch], j),
                           last: (b == BB - 1) && (j == WPB - 1), ch: 4'(ch)});
         exp_n[ch]++;
      end
      exp_seq++;
   endtask

   // Ready-mask watcher: any tready bit outside the allowed set is sticky-flagged.
   logic [NCH-1:0] rdy_allow = '0;
   logic           bad_rdy   = 1'b0;
   always @(negedge clk) if ((s_axis_tready & ~rdy_allow) != '0) bad_rdy = 1'b1;

   // Monitor: compare accepted words and hold-stability of stalled words.
   logic          held = 1'b0;
   logic [OW-1:0] held_data;
   always @(negedge clk) begin
      if (held) begin
         checks++;
         if (!m_axis_tvalid || m_axis_tdata !== held_data) begin
            errors++;
            $display("FAIL hold: got valid=%b data=%h want valid=1 data=%h",
                     m_axis_tvalid, m_axis_tdata, held_data);
         end
      end
      held = 1'b0;
      if (rst && m_axis_tvalid) begin
         if (m_axis_tready) begin
            hs_cnt++;
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL extra_word: got data=%h want no word", m_axis_tdata);
            end else begin
               exp_t e;
               e = sb.pop_front();
               if (m_axis_tdata !== e.data || m_axis_tlast !== e.last || cur_ch !== e.ch) begin
                  errors++;
                  $display("FAIL word%0d: got data=%h last=%b ch=%0d want data=%h last=%b ch=%0d",
                           hs_cnt, m_axis_tdata, m_axis_tlast, cur_ch, e.data, e.last, e.ch);
               end
            end
         end else begin
            held      = 1'b1;
            held_data = m_axis_tdata;
         end
      end
      if (!rst) held = 1'b0;
   end

   // PS back-pressure pattern 1,0,0,1 when enabled
   logic        bp_mode = 1'b0;
   logic [3:0]  bp_pat  = 4'b1001;
   int unsigned bp_i    = 0;
   always @(posedge clk) begin
      #1;
      if (bp_mode) begin
         m_axis_tready = bp_pat[bp_i];
         bp_i          = (bp_i + 1) % 4;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic wait_words(input int unsigned target, input int unsigned budget);
      int unsigned c = 0;
      while (hs_cnt < target && c < budget) begin
         @(posedge clk); #1;
         c++;
      end
      checks++;
      if (hs_cnt < target) begin
         errors++;
         $display("FAIL wait_words: got %0d words want %0d", hs_cnt, target);
      end
   endtask

   task automatic wait_drain(input string name, input int unsigned budget);
      int unsigned c = 0;
      while ((sb.size() != 0 || busy) && c < budget) begin
         @(posedge clk); #1;
         c++;
      end
      checks++;
      if (sb.size() != 0 || busy) begin
         errors++;
         $display("FAIL %s_drain: got pending=%0d busy=%b want pending=0 busy=0",
                  name, sb.size(), busy);
      end
   endtask

   task automatic chk_idle_outputs(input string name);
      chk({name, "_s_tready"}, 64'(s_axis_tready), 64'd0);
      chk({name, "_tvalid"},   64'(m_axis_tvalid), 64'd0);
      chk({name, "_tlast"},    64'(m_axis_tlast),  64'd0);
      chk({name, "_tdata"},    64'(m_axis_tdata),  64'd0);
      chk({name, "_busy"},     64'(busy),          64'd0);
      chk({name, "_cur_ch"},   64'(cur_ch),        64'd0);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst     = 1'b1;
      exp_seq = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned base;
      rst = 1'b0; ch_en = '0; src_v = '0; m_axis_tready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_idle_outputs("reset");
      rst = 1'b1;

      // Single channel, continuous PS ready
      rdy_allow = 16'h0001; bad_rdy = 1'b0;
      src_v = 16'h0001; ch_en = 16'h0001;
      push_burst(0);
      base = hs_cnt;
      wait_words(base + 1, 50);
      ch_en = '0;
      wait_drain("single", 200);
      repeat (5) @(posedge clk);
      #1;
      chk("single_idle_busy", 64'(busy), 64'd0);
      chk("single_rdy_only", 64'(bad_rdy), 64'd0);
      src_v = '0;

      // Round-robin among 0, 2, 15 from reset
      do_reset();
      rdy_allow = 16'h8005; bad_rdy = 1'b0;
      src_v = 16'h8005; ch_en = 16'h8005;
      push_burst(0); push_burst(2); push_burst(15); push_burst(0); push_burst(2);
      base = hs_cnt;
      wait_words(base + 4 * BW + 1, 400);
      ch_en = '0;
      wait_drain("rr", 200);
      chk("rr_rdy_only", 64'(bad_rdy), 64'd0);
      src_v = '0;

      // Back-pressure on the PS side
      rdy_allow = 16'h0008; bad_rdy = 1'b0;
      src_v = 16'h0008; ch_en = 16'h0008;
      push_burst(3);
      bp_i = 0; bp_mode = 1'b1;
      base = hs_cnt;
      wait_words(base + 1, 50);
      ch_en = '0;
      wait_drain("bp", 300);
      bp_mode = 1'b0; m_axis_tready = 1'b1;
      chk("bp_rdy_only", 64'(bad_rdy), 64'd0);
      src_v = '0;

      // Enable dropped mid-burst: burst completes, then stays idle
      rdy_allow = 16'h0002; bad_rdy = 1'b0;
      src_v = 16'h0002; ch_en = 16'h0002;
      push_burst(1);
      base = hs_cnt;
      wait_words(base + HW + WPB + 1, 60);
      ch_en = '0;
      wait_drain("dis", 200);
      repeat (10) @(posedge clk);
      #1;
      chk("dis_idle_busy", 64'(busy), 64'd0);
      chk("dis_idle_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("dis_rdy_only", 64'(bad_rdy), 64'd0);
      src_v = '0;

      // Reset in the middle of SHIFT
      rdy_allow = 16'h0011; bad_rdy = 1'b0;
      src_v = 16'h0010; ch_en = 16'h0010;
      push_hdr(4);
      sb.push_back('{data: word_of(4, exp_n[4], 0), last: 1'b0, ch: 4'd4});
      sb.push_back('{data: word_of(4, exp_n[4], 1), last: 1'b0, ch: 4'd4});
      exp_n[4]++;
      base = hs_cnt;
      wait_words(base + HW + 2, 60);
      m_axis_tready = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst     = 1'b1;
      exp_seq = '0;
      chk_idle_outputs("midrst");
      chk("midrst_sb_empty", 64'(sb.size()), 64'd0);
      ch_en = 16'h0011; src_v = 16'h0011; m_axis_tready = 1'b1;
      push_burst(0);
      base = hs_cnt;
      wait_words(base + 1, 50);
      ch_en = '0;
      wait_drain("postrst", 200);
      chk("postrst_rdy_only", 64'(bad_rdy), 64'd0);
      src_v = '0;

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
